// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// pipeline stall bit positions and the stall vector for each stall cause.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_BUSY = 3'd1,
    MEM_DONE = 3'd2,
    IF_BUSY  = 3'd3,
    IF_DONE  = 3'd4
  } arb_state_e;

  // Stall vector bit positions, one per pipeline register.
  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB     = 5;
  localparam int STALL_W      = STALL_WB + 1;

  // Each cause freezes every register up to and including its own stage.
  localparam logic [STALL_W-1:0] STALL_NONE = '0;
  localparam logic [STALL_W-1:0] STALL_IF   = (STALL_W'(1) << STALL_PC) |
                                              (STALL_W'(1) << STALL_IF_ID);
  localparam logic [STALL_W-1:0] STALL_ID   = STALL_IF | (STALL_W'(1) << STALL_ID_EX);
  localparam logic [STALL_W-1:0] STALL_EX   = STALL_ID | (STALL_W'(1) << STALL_EX_MEM);
  localparam logic [STALL_W-1:0] STALL_MEM  = STALL_EX | (STALL_W'(1) << STALL_MEM_WB);

  function automatic logic is_busy(input arb_state_e s);
    return (s == MEM_BUSY) || (s == IF_BUSY);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog: counts cycles a transaction waits without acknowledge.
//   clk, rst  : clock, asynchronous active-low reset
//   clr       : hold counter at zero (asserted whenever no transaction is open)
//   en        : count this cycle (transaction open, no ack)
//   expired   : this un-acked cycle brings the count to TIMEOUT
module mem_bus_arbiter_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= cnt + CNT_W'(1);
  end

  // Flag the cycle whose increment would reach TIMEOUT, so the bus strobe
  // is held for exactly TIMEOUT cycles before the abort takes effect.
  assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one external bus between instruction fetch and
// the MEM-stage load/store port (MEM has priority), produces the pipeline
// stall vector and aborts transactions that never acknowledge.
//   clk, rst                         : clock, asynchronous active-low reset
//   if_req/if_addr/if_rdata          : fetch request, address, fetched word
//   mem_req/we/addr/wdata/sel/rdata  : MEM-stage access request and load data
//   ex_stallreq, id_stallreq         : stall requests from EX and ID
//   stall[5:0]                       : PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB
//   bus_req/we/addr/wdata/sel        : registered bus master outputs
//   bus_rdata, bus_ack               : bus response
//   bus_err                          : one-cycle pulse on watchdog abort
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_sel,
  output logic [31:0]        mem_rdata,
  input  logic               ex_stallreq,
  input  logic               id_stallreq,
  output logic [STALL_W-1:0] stall,
  output logic               bus_req,
  output logic               bus_we,
  output logic [31:0]        bus_addr,
  output logic [31:0]        bus_wdata,
  output logic [3:0]         bus_sel,
  input  logic [31:0]        bus_rdata,
  input  logic               bus_ack,
  output logic               bus_err
);

  arb_state_e state, state_nxt;
  logic       busy;
  logic       abort;
  logic       load_mem;
  logic       load_if;

  assign busy = is_busy(state);

  mem_bus_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy),
    .en      (busy && !bus_ack),
    .expired (abort)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_req)     state_nxt = MEM_BUSY;
        else if (if_req) state_nxt = IF_BUSY;
      end
      MEM_BUSY: if (bus_ack || abort) state_nxt = MEM_DONE;
      IF_BUSY:  if (bus_ack || abort) state_nxt = IF_DONE;
      // A fetch waiting behind a MEM access starts without an idle bubble.
      MEM_DONE: state_nxt = if_req ? IF_BUSY : IDLE;
      IF_DONE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus_req = busy;
    if (mem_req && state != MEM_DONE) stall = STALL_MEM;
    else if (ex_stallreq)             stall = STALL_EX;
    else if (id_stallreq)             stall = STALL_ID;
    else if (if_req && state != IF_DONE) stall = STALL_IF;
    else                              stall = STALL_NONE;
  end

  assign load_mem = (state_nxt == MEM_BUSY) && !busy;
  assign load_if  = (state_nxt == IF_BUSY)  && !busy;

  // Bus command registers, loaded on BUSY entry and held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_sel   <= '0;
    end else if (load_mem) begin
      bus_we    <= mem_we;
      bus_addr  <= mem_addr;
      bus_wdata <= mem_wdata;
      bus_sel   <= mem_sel;
    end else if (load_if) begin
      bus_we    <= 1'b0;
      bus_addr  <= if_addr;
      bus_wdata <= '0;
      bus_sel   <= '1;
    end
  end

  // Read data capture and abort pulse. A store or an abort captures zero;
  // abort already excludes the ack cycle, so ack wins a same-cycle race.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata  <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= abort;
      if (state == MEM_BUSY && (bus_ack || abort))
        mem_rdata <= (bus_ack && !bus_we) ? bus_rdata : '0;
      if (state == IF_BUSY && (bus_ack || abort))
        if_rdata <= bus_ack ? bus_rdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        ex_stallreq;
  logic        id_stallreq;
  logic [5:0]  stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        full;   // compare wdata/sel too (MEM accesses)
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          tests;
  int          fails;

  mem_bus_arbiter #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_sel     (mem_sel),
    .mem_rdata   (mem_rdata),
    .ex_stallreq (ex_stallreq),
    .id_stallreq (id_stallreq),
    .stall       (stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_sel     (bus_sel),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b0;
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0;
    mem_wdata = '0; mem_sel = '0; ex_stallreq = 0; id_stallreq = 0;
    bus_rdata = '0; bus_ack = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus_req, bus_we, bus_err} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 000", {bus_req, bus_we, bus_err});
    end
    tests++;
    if ({bus_addr, bus_wdata, bus_sel, if_rdata, mem_rdata} !== '0) begin
      fails++; $display("FAIL reset_data: got addr %h wdata %h sel %h if %h mem %h expected all 0",
                        bus_addr, bus_wdata, bus_sel, if_rdata, mem_rdata);
    end
    tests++;
    if (stall !== 6'b000000) begin
      fails++; $display("FAIL reset_stall: got %b expected 000000", stall);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_fetch();
    txn_t t;
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    exp_q.push_back('{addr: 32'h100, we: 1'b0, wdata: '0, sel: 4'hF, full: 1'b0});
    rd_q.push_back(32'h2402000A);
    #1;
    tests++;
    if (stall !== 6'b000011) begin
      fails++; $display("FAIL if_stall_req: got %b expected 000011", stall);
    end
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1) begin
      fails++; $display("FAIL if_bus_req: got %b expected 1", bus_req);
    end
    t = exp_q.pop_front();
    tests++;
    if ({bus_addr, bus_we} !== {t.addr, t.we}) begin
      fails++; $display("FAIL if_txn: got addr %h we %b expected addr %h we %b", bus_addr, bus_we, t.addr, t.we);
    end
    tests++;
    if (stall !== 6'b000011) begin
      fails++; $display("FAIL if_stall_busy: got %b expected 000011", stall);
    end
    @(negedge clk);
    tests++;
    if ({bus_req, bus_addr} !== {1'b1, 32'h100}) begin
      fails++; $display("FAIL if_hold: got req %b addr %h expected req 1 addr 00000100", bus_req, bus_addr);
    end
    bus_ack = 1; bus_rdata = 32'h2402000A;
    @(negedge clk);
    bus_ack = 0; bus_rdata = '0;
    tests++;
    if ({bus_req, stall} !== {1'b0, 6'b000000}) begin
      fails++; $display("FAIL if_done: got req %b stall %b expected req 0 stall 000000", bus_req, stall);
    end
    tests++;
    if (if_rdata !== rd_q[0]) begin
      fails++; $display("FAIL if_rdata: got %h expected %h", if_rdata, rd_q[0]);
    end
    void'(rd_q.pop_front());
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_mem_during_if();
    txn_t t;
    @(negedge clk);
    if_req = 1; if_addr = 32'h104;
    exp_q.push_back('{addr: 32'h104, we: 1'b0, wdata: '0, sel: 4'hF, full: 1'b0});
    exp_q.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0, sel: 4'hF, full: 1'b1});
    rd_q.push_back(32'h11112222);
    rd_q.push_back(32'h55AA55AA);
    @(negedge clk);
    t = exp_q.pop_front();
    tests++;
    if ({bus_req, bus_addr, bus_we} !== {1'b1, t.addr, t.we}) begin
      fails++; $display("FAIL mif_if_txn: got req %b addr %h we %b expected req 1 addr %h we %b",
                        bus_req, bus_addr, bus_we, t.addr, t.we);
    end
    mem_req = 1; mem_we = 0; mem_addr = 32'h400; mem_wdata = '0; mem_sel = 4'hF;
    #1;
    tests++;
    if (stall !== 6'b011111) begin
      fails++; $display("FAIL mif_stall_busy: got %b expected 011111", stall);
    end
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h11112222;
    @(negedge clk);
    bus_ack = 0; bus_rdata = '0;
    tests++;
    if ({bus_req, stall} !== {1'b0, 6'b011111}) begin
      fails++; $display("FAIL mif_if_done: got req %b stall %b expected req 0 stall 011111", bus_req, stall);
    end
    tests++;
    if (if_rdata !== rd_q[0]) begin
      fails++; $display("FAIL mif_if_rdata: got %h expected %h", if_rdata, rd_q[0]);
    end
    void'(rd_q.pop_front());
    if_req = 0;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b0) begin
      fails++; $display("FAIL mif_idle: got req %b expected 0", bus_req);
    end
    @(negedge clk);
    t = exp_q.pop_front();
    tests++;
    if ({bus_req, bus_addr, bus_we, bus_wdata, bus_sel} !== {1'b1, t.addr, t.we, t.wdata, t.sel}) begin
      fails++; $display("FAIL mif_mem_txn: got req %b addr %h we %b wdata %h sel %h expected addr %h we %b wdata %h sel %h",
                        bus_req, bus_addr, bus_we, bus_wdata, bus_sel, t.addr, t.we, t.wdata, t.sel);
    end
    bus_ack = 1; bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    bus_ack = 0; bus_rdata = '0;
    tests++;
    if ({mem_rdata, stall} !== {rd_q[0], 6'b000000}) begin
      fails++; $display("FAIL mif_mem_done: got rdata %h stall %b expected rdata %h stall 000000",
                        mem_rdata, stall, rd_q[0]);
    end
    void'(rd_q.pop_front());
    mem_req = 0;
    @(negedge clk);
  endtask

  task automatic test_mem_if_together();
    txn_t t;
    @(negedge clk);
    if_req = 1; if_addr = 32'h300;
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF; mem_sel = 4'hF;
    exp_q.push_back('{addr: 32'h200, we: 1'b1, wdata: 32'hDEADBEEF, sel: 4'hF, full: 1'b1});
    exp_q.push_back('{addr: 32'h300, we: 1'b0, wdata: '0, sel: 4'hF, full: 1'b0});
    rd_q.push_back(32'h0);
    rd_q.push_back(32'hCAFEF00D);
    #1;
    tests++;
    if (stall !== 6'b011111) begin
      fails++; $display("FAIL both_stall_req: got %b expected 011111", stall);
    end
    @(negedge clk);
    t = exp_q.pop_front();
    tests++;
    if ({bus_req, bus_addr, bus_we, bus_wdata, bus_sel} !== {1'b1, t.addr, t.we, t.wdata, t.sel}) begin
      fails++; $display("FAIL both_mem_txn: got req %b addr %h we %b wdata %h sel %h expected addr %h we %b wdata %h sel %h",
                        bus_req, bus_addr, bus_we, bus_wdata, bus_sel, t.addr, t.we, t.wdata, t.sel);
    end
    bus_ack = 1; bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_ack = 0; bus_rdata = '0;
    tests++;
    if ({bus_req, stall} !== {1'b0, 6'b000011}) begin
      fails++; $display("FAIL both_mem_done: got req %b stall %b expected req 0 stall 000011", bus_req, stall);
    end
    tests++;
    if (mem_rdata !== rd_q[0]) begin
      fails++; $display("FAIL both_store_rdata: got %h expected %h", mem_rdata, rd_q[0]);
    end
    void'(rd_q.pop_front());
    mem_req = 0; mem_we = 0;
    @(negedge clk);
    t = exp_q.pop_front();
    tests++;
    if ({bus_req, bus_addr, bus_we} !== {1'b1, t.addr, t.we}) begin
      fails++; $display("FAIL both_if_no_bubble: got req %b addr %h we %b expected req 1 addr %h we %b",
                        bus_req, bus_addr, bus_we, t.addr, t.we);
    end
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_ack = 0; bus_rdata = '0;
    tests++;
    if ({if_rdata, stall} !== {rd_q[0], 6'b000000}) begin
      fails++; $display("FAIL both_if_done: got rdata %h stall %b expected rdata %h stall 000000",
                        if_rdata, stall, rd_q[0]);
    end
    void'(rd_q.pop_front());
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    txn_t t;
    int   n_req;
    int   n_err;
    bit   done_seen;
    bit   txn_checked;
    // Ack arriving in the last allowed cycle must win over the abort.
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_addr = 32'h600; mem_wdata = '0; mem_sel = 4'hF;
    rd_q.push_back(32'h0BADF00D);
    repeat (3) @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1) begin
      fails++; $display("FAIL to_race_busy: got req %b expected 1", bus_req);
    end
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus_ack = 0; bus_rdata = '0;
    tests++;
    if ({bus_req, bus_err, mem_rdata} !== {1'b0, 1'b0, rd_q[0]}) begin
      fails++; $display("FAIL to_race_done: got req %b err %b rdata %h expected req 0 err 0 rdata %h",
                        bus_req, bus_err, mem_rdata, rd_q[0]);
    end
    void'(rd_q.pop_front());
    mem_req = 0;
    @(negedge clk);
    tests++;
    if (bus_err !== 1'b0) begin
      fails++; $display("FAIL to_race_err: got %b expected 0", bus_err);
    end
    // No ack at all: abort after four strobe cycles.
    mem_req = 1; mem_addr = 32'h500;
    exp_q.push_back('{addr: 32'h500, we: 1'b0, wdata: '0, sel: 4'hF, full: 1'b1});
    rd_q.push_back(32'h0);
    n_req = 0; n_err = 0; done_seen = 0; txn_checked = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1) n_req++;
      if (bus_err === 1'b1) n_err++;
      if (bus_req === 1'b1 && !txn_checked) begin
        txn_checked = 1;
        t = exp_q.pop_front();
        tests++;
        if ({bus_addr, bus_we, bus_sel} !== {t.addr, t.we, t.sel}) begin
          fails++; $display("FAIL to_txn: got addr %h we %b sel %h expected addr %h we %b sel %h",
                            bus_addr, bus_we, bus_sel, t.addr, t.we, t.sel);
        end
      end
      if (bus_req !== 1'b1 && n_req > 0 && !done_seen) begin
        done_seen = 1;
        tests++;
        if ({bus_err, stall, mem_rdata} !== {1'b1, 6'b000000, rd_q[0]}) begin
          fails++; $display("FAIL to_done: got err %b stall %b rdata %h expected err 1 stall 000000 rdata %h",
                            bus_err, stall, mem_rdata, rd_q[0]);
        end
        void'(rd_q.pop_front());
        mem_req = 0;
      end
    end
    tests++;
    if (!done_seen || !txn_checked) begin
      fails++; $display("FAIL to_no_release: got done %b strobe %b expected 1 1", done_seen, txn_checked);
      exp_q.delete(); rd_q.delete(); mem_req = 0;
    end
    tests++;
    if (n_req != 4) begin
      fails++; $display("FAIL to_req_cycles: got %0d expected 4", n_req);
    end
    tests++;
    if (n_err != 1) begin
      fails++; $display("FAIL to_err_pulses: got %0d expected 1", n_err);
    end
  endtask

  task automatic test_stall_priority();
    // mem, ex, id, if, expected stall
    logic [9:0] tbl [7];
    tbl[0] = {4'b0100, 6'b001111};
    tbl[1] = {4'b0110, 6'b001111};
    tbl[2] = {4'b0010, 6'b000111};
    tbl[3] = {4'b0001, 6'b000011};
    tbl[4] = {4'b0011, 6'b000111};
    tbl[5] = {4'b1111, 6'b011111};
    tbl[6] = {4'b0000, 6'b000000};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      {mem_req, ex_stallreq, id_stallreq, if_req} = tbl[i][9:6];
      #1;
      tests++;
      if (stall !== tbl[i][5:0]) begin
        fails++; $display("FAIL stall_prio[%0d]: got %b expected %b", i, stall, tbl[i][5:0]);
      end
      #1;
      mem_req = 0; if_req = 0;
    end
    ex_stallreq = 0; id_stallreq = 0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    txn_t t;
    @(negedge clk);
    if_req = 1; if_addr = 32'h700;
    exp_q.push_back('{addr: 32'h700, we: 1'b0, wdata: '0, sel: 4'hF, full: 1'b0});
    @(negedge clk);
    t = exp_q.pop_front();
    tests++;
    if ({bus_req, bus_addr} !== {1'b1, t.addr}) begin
      fails++; $display("FAIL ar_busy: got req %b addr %h expected req 1 addr %h", bus_req, bus_addr, t.addr);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({bus_req, bus_addr, if_rdata, mem_rdata} !== '0) begin
      fails++; $display("FAIL ar_async: got req %b addr %h if %h mem %h expected all 0",
                        bus_req, bus_addr, if_rdata, mem_rdata);
    end
    tests++;
    if (stall !== 6'b000011) begin
      fails++; $display("FAIL ar_stall: got %b expected 000011", stall);
    end
    if_req = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b0) begin
      fails++; $display("FAIL ar_idle: got req %b expected 0", bus_req);
    end
    if_req = 1; if_addr = 32'h708;
    exp_q.push_back('{addr: 32'h708, we: 1'b0, wdata: '0, sel: 4'hF, full: 1'b0});
    rd_q.push_back(32'h3C3C3C3C);
    @(negedge clk);
    t = exp_q.pop_front();
    tests++;
    if ({bus_req, bus_addr} !== {1'b1, t.addr}) begin
      fails++; $display("FAIL ar_refetch: got req %b addr %h expected req 1 addr %h", bus_req, bus_addr, t.addr);
    end
    bus_ack = 1; bus_rdata = 32'h3C3C3C3C;
    @(negedge clk);
    bus_ack = 0; bus_rdata = '0;
    tests++;
    if ({bus_req, if_rdata} !== {1'b0, rd_q[0]}) begin
      fails++; $display("FAIL ar_rdata: got req %b rdata %h expected req 0 rdata %h", bus_req, if_rdata, rd_q[0]);
    end
    void'(rd_q.pop_front());
    if_req = 0;
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_if_fetch();
    test_mem_during_if();
    test_mem_if_together();
    test_timeout();
    test_stall_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
